// File: rtl/project_pwm_capture.sv
// PWM input capture: measures period and high time between accepted edges of an async input.
// Optional stability filter on the synchronized input, enabled by PWM_CAPTURE_FILTER_EN.
module project_pwm_capture #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_pwm,
    input  logic             i_ack,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_overrun,
    output logic             o_timeout,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StArm      = 2'd1,
        StHighWait = 2'd2,
        StLow      = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);
    localparam logic [WIDTH-1:0] CntMax = '1;

    logic s1_q, s2_q, prev_q, level;
    logic rise, fall;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= i_pwm;
            s2_q   <= s1_q;
            prev_q <= level;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic       filt_q, filt_d;
    logic [3:0] fcnt_q, fcnt_d;

    // Level flips only after s2 has disagreed with it for FILTER_LEN consecutive cycles.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = 4'd0;
        if (s2_q != filt_q) begin
            if (fcnt_q == 4'(FILTER_LEN - 1)) begin
                filt_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            filt_q <= 1'b0;
            fcnt_q <= 4'd0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign level = s2_q;
`endif

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             result, timeout_set;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        result      = 1'b0;
        timeout_set = 1'b0;
        if (!i_en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (rise) begin
                        cnt_d   = CntOne;
                        state_d = StHighWait;
                    end
                end
                StHighWait: begin
                    if (rise) begin
                        cnt_d = CntOne;
                    end else if (fall) begin
                        shadow_d = cnt_q;
                        cnt_d    = cnt_inc;
                        state_d  = StLow;
                    end else if (cnt_q == CntMax) begin
                        timeout_set = 1'b1;
                        cnt_d       = '0;
                        state_d     = StArm;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StLow: begin
                    if (rise) begin
                        result  = 1'b1;
                        cnt_d   = CntOne;
                        state_d = StHighWait;
                    end else if (cnt_q == CntMax) begin
                        timeout_set = 1'b1;
                        cnt_d       = '0;
                        state_d     = StArm;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
    logic             valid_q, valid_d, overrun_q, overrun_d, timeout_q, timeout_d;

    // Set conditions are applied after clear so that set wins in the same cycle.
    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (i_clear) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (result) begin
            if (!valid_q || i_ack) begin
                period_d = cnt_q;
                high_d   = shadow_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (i_ack) begin
            valid_d = 1'b0;
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shadow_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
    assign o_timeout = timeout_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_project_pwm_capture.sv
// Bench for project_pwm_capture: directed and random PWM waves against an edge-timing model.
module tb_project_pwm_capture;

    localparam int unsigned WIDTH = 16;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int AckLead = 5;
`else
    localparam int AckLead = 2;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset, i_en, i_pwm, i_ack, i_clear;
    logic [WIDTH-1:0] o_period, o_high;
    logic             o_valid, o_overrun, o_timeout;
    logic [1:0]       o_state;

    project_pwm_capture #(.WIDTH(WIDTH), .FILTER_LEN(3)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_en      (i_en),
        .i_pwm     (i_pwm),
        .i_ack     (i_ack),
        .i_clear   (i_clear),
        .o_period  (o_period),
        .o_high    (o_high),
        .o_valid   (o_valid),
        .o_overrun (o_overrun),
        .o_timeout (o_timeout),
        .o_state   (o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int per;
        int hi;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   last_per = 0;
    int   last_hi = 0;
    bit   have_rise = 0;
    bit   have_fall = 0;
    bit   auto_ack = 1;
    logic mprev = 1'b0;
    res_t r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    // v drives the pin; mv is the level the model believes is a real edge (differs for glitches).
    task automatic stepm(input logic v, input logic mv);
        i_pwm = v;
        cyc++;
        if (mv && !mprev) begin
            if (have_rise && have_fall) exp_q.push_back('{cyc - rise_cyc, fall_cyc - rise_cyc});
            rise_cyc  = cyc;
            have_rise = 1;
            have_fall = 0;
        end else if (!mv && mprev) begin
            fall_cyc  = cyc;
            have_fall = 1;
        end
        mprev = mv;
        @(posedge i_clk);
        #1;
        if (auto_ack) begin
            if (o_valid && !i_ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(o_valid), 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("period", 32'(o_period), r.per);
                    chk("high", 32'(o_high), r.hi);
                    last_per = r.per;
                    last_hi  = r.hi;
                end
                i_ack = 1'b1;
            end else begin
                i_ack = 1'b0;
            end
        end
    endtask

    task automatic step(input logic v);
        stepm(v, v);
    endtask

    task automatic wave(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) step(1'b1);
            repeat (l) step(1'b0);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic model_rearm();
        have_rise = 0;
        have_fall = 0;
    endtask

    task automatic toggle_en();
        i_en = 1'b0;
        step(1'b0);
        i_en = 1'b1;
        repeat (3) step(1'b0);
        model_rearm();
    endtask

    initial begin
        i_reset = 1'b0;
        i_en    = 1'b1;
        i_pwm   = 1'b0;
        i_ack   = 1'b0;
        i_clear = 1'b0;
        #12;
        chk("rst_period", 32'(o_period), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_state", 32'(o_state), 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        settle(4);

        // 60-cycle period, 29 high
        wave(29, 31, 4);
        settle(10);
        chk("basic_ack_clears", 32'(o_valid), 0);
        chk("basic_last_period", last_per, 60);

        repeat (12) wave(int'($urandom_range(4, 30)), int'($urandom_range(4, 30)), 1);
        settle(10);

        // Disable holds the last result
        i_en = 1'b0;
        step(1'b0);
        chk("en_hold_period", 32'(o_period), last_per);
        chk("en_hold_high", 32'(o_high), last_hi);
        chk("en_idle_state", 32'(o_state), 0);
        i_en = 1'b1;
        repeat (3) step(1'b0);
        model_rearm();

        // Overrun: no ack for three results
        auto_ack = 0;
        wave(5, 15, 4);
        settle(6);
        chk("ovr_valid", 32'(o_valid), 1);
        chk("ovr_period", 32'(o_period), 20);
        chk("ovr_high", 32'(o_high), 5);
        chk("ovr_flag", 32'(o_overrun), 1);
        exp_q.delete();
        i_clear = 1'b1;
        step(1'b0);
        i_clear = 1'b0;
        chk("ovr_cleared", 32'(o_overrun), 0);
        chk("ovr_valid_kept", 32'(o_valid), 1);

        // Ack lands in the same cycle as a new result
        step(1'b1);
        repeat (AckLead - 1) step(1'b1);
        i_ack = 1'b1;
        step(1'b1);
        i_ack = 1'b0;
        r = exp_q[$];
        chk("sim_valid", 32'(o_valid), 1);
        chk("sim_period", 32'(o_period), r.per);
        chk("sim_high", 32'(o_high), r.hi);
        chk("sim_no_overrun", 32'(o_overrun), 0);
        exp_q.delete();
        repeat (2) step(1'b1);
        settle(5);

        // Asynchronous reset mid-measurement
        i_pwm = 1'b0;
        #2;
        i_reset = 1'b0;
        #1;
        chk("arst_period", 32'(o_period), 0);
        chk("arst_high", 32'(o_high), 0);
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_state", 32'(o_state), 0);
        exp_q.delete();
        model_rearm();
        @(posedge i_clk);
        #1;
        i_reset  = 1'b1;
        auto_ack = 1;
        settle(3);
        wave(4, 6, 1);
        settle(10);
        chk("first_rise_no_result", 32'(o_valid), 0);
        wave(4, 6, 2);
        settle(10);

        // Timeout on 100% duty
        toggle_en();
        step(1'b1);
        repeat (64999) step(1'b1);
        chk("to_not_yet", 32'(o_timeout), 0);
        chk("to_high_state", 32'(o_state), 2);
        repeat (600 + AckLead) step(1'b1);
        chk("to_flag", 32'(o_timeout), 1);
        chk("to_arm_state", 32'(o_state), 1);
        model_rearm();
        settle(5);
        wave(7, 13, 2);
        settle(10);
        chk("to_recovered", last_per, 20);
        chk("to_sticky", 32'(o_timeout), 1);
        i_clear = 1'b1;
        step(1'b0);
        i_clear = 1'b0;
        chk("to_cleared", 32'(o_timeout), 0);

`ifdef PWM_CAPTURE_FILTER_EN
        // 2-cycle glitches in the low phase must be rejected
        toggle_en();
        repeat (3) begin
            repeat (10) step(1'b1);
            repeat (10) step(1'b0);
            repeat (2) stepm(1'b1, 1'b0);
            repeat (18) step(1'b0);
        end
        wave(10, 30, 1);
        settle(10);
        chk("filt_period", last_per, 40);
        chk("filt_high", last_hi, 10);
`endif

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/project_pwm_capture.md
Name: project_pwm_capture

Overview:
- Input-capture block: measures the period and high time of an external PWM waveform, such as one produced by the peripheral's comparator/deadband chain.
- Returns the results to software/test logic through a valid/ack handshake.
- Contents: input synchronizer, edge detector, cycle counter, capture FSM and status flags.
- Used for loopback self-test of the PWM outputs and as a general-purpose capture channel.

Parameters:
- WIDTH, 16: counter and result width in bits.
- FILTER_LEN, 3: cycles the synchronized input must be stable before an edge is accepted. Used only when PWM_CAPTURE_FILTER_EN is defined; legal range 2..15.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_en  input  1  capture enable.
- i_pwm  input  1  asynchronous PWM input to measure.
- i_ack  input  1  one-cycle acknowledge; consumes the current result.
- i_clear  input  1  synchronous clear of the sticky flags o_overrun and o_timeout.
- o_period  output  WIDTH  clock cycles between consecutive accepted rising edges.
- o_high  output  WIDTH  clock cycles from an accepted rising edge to the following accepted falling edge.
- o_valid  output  1  result available; held until acknowledged.
- o_overrun  output  1  sticky; a new result was dropped because o_valid was still set.
- o_timeout  output  1  sticky; counter saturated without seeing the expected edge.
- o_state  output  2  current FSM state, for debug.

Behaviour:
- Reset (i_reset=0, asynchronous): every output is 0, synchronizer flops are 0, cnt=0, state=IDLE.
- Input path:
  - Two-flop synchronizer s1 -> s2, then a previous-value flop prev.
  - rise = s2 & ~prev; fall = ~s2 & prev.
  - An input edge is seen as rise/fall exactly 3 clocks after it reaches the s1 flop.
- Counter cnt (WIDTH bits):
  - On an accepted rise while in HIGH_WAIT or LOW: cnt <= 1.
  - Otherwise increments by 1 while state is HIGH_WAIT or LOW.
  - Saturates at all-ones and never wraps.
  - Consequence: if the rise occurs in cycle t, cnt = j in cycle t+j.
- FSM states: IDLE=0, ARM=1, HIGH_WAIT=2, LOW=3.
  - IDLE: entered whenever i_en=0 (forced from any state, cnt <= 0). Goes to ARM when i_en=1.
  - ARM: waits for the first rise. On rise: cnt <= 1, go to HIGH_WAIT. No result is produced.
  - HIGH_WAIT: on fall, high_shadow <= cnt, go to LOW.
  - LOW: on rise, the result becomes {period=cnt, high=high_shadow}; cnt <= 1; go to HIGH_WAIT.
  - Timeout: if cnt is all-ones in HIGH_WAIT or LOW and the expected edge is absent that cycle, set o_timeout and go to ARM. This covers 0% and 100% duty.
- Result handshake (result produced in cycle t):
  - If o_valid=0, or i_ack=1 in cycle t: o_period/o_high load, and o_valid=1 from cycle t+1.
  - If o_valid=1 and i_ack=0: the result is dropped, outputs keep the old values, and o_overrun is set.
  - i_ack with no new result: o_valid <= 0; data outputs hold their last value.
  - i_ack while o_valid=0: ignored.
- Flags:
  - i_clear clears o_overrun and o_timeout next cycle.
  - If i_clear and a set condition occur in the same cycle, set wins.
- i_en deassertion: current measurement is aborted; o_valid, o_period and o_high hold; flags hold.
- Period minimum: the first ARM-to-HIGH_WAIT measurement is never reported.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A stability filter sits between s2 and the edge detector. The filtered level changes only after s2 has differed from it for FILTER_LEN consecutive cycles.
  - rise/fall are computed on the filtered level, so pulses shorter than FILTER_LEN cycles are rejected.
  - Added latency is FILTER_LEN cycles, applied equally to both edges, so measured values are unchanged.
  - Filter counter resets to 0 and the filtered level resets to 0.
- Not defined: no filter logic; the edge detector uses s2 directly; FILTER_LEN is unused.

Test Plan:
- Reset check: assert i_reset=0 mid-measurement -> all outputs 0 immediately; after release, first rise produces no result.
- Basic measurement: i_en=1, square wave period 60 clocks, high 29 -> after the second rise, o_valid=1, o_period=60, o_high=29; i_ack -> o_valid=0 next cycle; steady stream gives 60/29 every period.
- Overrun: period 20, high 5, no i_ack for 3 periods -> o_valid stays 1 with the first result 20/5; o_overrun=1; i_clear -> o_overrun=0.
- Simultaneous ack and new result: pulse i_ack in the exact cycle of a new result -> o_valid stays 1, new data loaded, o_overrun stays 0.
- Timeout: hold i_pwm=1 after a rise (WIDTH=16) -> o_timeout=1 at cnt=16'hFFFF, state returns to ARM; the next two rises yield a correct result.
- Filter (macro defined, FILTER_LEN=3): 2-cycle glitches inside a 40-cycle-period, 10-cycle-high wave -> results remain 40/10. With the macro undefined, the same stimulus produces corrupted results.
